// File: rtl/conv_encoder_sys.sv
// Rate-1/2 feed-forward convolutional encoder with selectable constraint
// length (3..6) and automatic zero-tail termination at end of frame.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   choose_constraint_length   K select (clamped to 3..6), sampled at frame start
//   in_valid/in_ready          input handshake for in_bit/in_last
//   in_bit, in_last            information bit, last-bit-of-frame marker
//   encoded_bits               [1]=g0 parity, [0]=g1 parity
//   out_valid/out_ready        output handshake for encoded_bits/out_last
//   out_last                   set on the final tail symbol of a frame
//   busy                       high while a frame is in DATA or TAIL
//   frame_bits                 info bits accepted in current/last frame (saturating)
module conv_encoder_sys #(
    parameter int unsigned MAX_K       = 6,   // must be >= 6 (generator tables cover K<=6)
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             choose_constraint_length,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_bit,
    input  logic                   in_last,
    output logic [1:0]             encoded_bits,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_bits
);

    localparam int unsigned SR_W  = MAX_K - 1;
    localparam int unsigned KW    = 3;
    localparam int unsigned GEN_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } state_e;

    // Map any select value onto the legal range 3..6.
    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
        if (k < 3'd3) begin
            return 3'd3;
        end else if (k > 3'd6) begin
            return 3'd6;
        end else begin
            return k;
        end
    endfunction

    // Generators stored MSB-aligned in 6 bits; MSB taps the current bit.
    function automatic logic [GEN_W-1:0] gen_g0(input logic [KW-1:0] k);
        case (k)
            3'd3:    return 6'b111000; // 7
            3'd4:    return 6'b110100; // 15
            3'd5:    return 6'b100110; // 23
            default: return 6'b101011; // 53
        endcase
    endfunction

    function automatic logic [GEN_W-1:0] gen_g1(input logic [KW-1:0] k);
        case (k)
            3'd3:    return 6'b101000; // 5
            3'd4:    return 6'b111100; // 17
            3'd5:    return 6'b111010; // 35
            default: return 6'b111101; // 75
        endcase
    endfunction

    // Place a 6-bit generator at the top of the MAX_K-wide window.
    function automatic logic [MAX_K-1:0] align_gen(input logic [GEN_W-1:0] g);
        return MAX_K'(g) << (MAX_K - GEN_W);
    endfunction

    state_e                 state_q, state_d;
    logic [SR_W-1:0]        sr_q, sr_d;       // sr_q[SR_W-1] is the most recent past bit
    logic [KW-1:0]          k_q, k_d;
    logic [KW-1:0]          tail_q, tail_d;
    logic [FRAME_CNT_W-1:0] fb_q, fb_d;
    logic                   ov_q, ov_d;
    logic [1:0]             enc_q, enc_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;

    logic                   slot_free_c;
    logic                   in_ready_c;
    logic [KW-1:0]          k_sel_c;
    logic [MAX_K-1:0]       g0_c, g1_c;
    logic [MAX_K-1:0]       wnd_c;
    logic                   shift_in_c;
    logic [SR_W-1:0]        hist_c;
    logic                   load_c;
    logic                   last_sym_c;

    assign slot_free_c = !ov_q || out_ready;
    assign in_ready_c  = ((state_q == ST_IDLE) || (state_q == ST_DATA)) && slot_free_c;

    // Next-state, shift-register and output-stage logic.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        k_d        = k_q;
        tail_d     = tail_q;
        fb_d       = fb_q;
        ov_d       = ov_q;
        enc_d      = enc_q;
        last_d     = last_q;
        shift_in_c = 1'b0;
        hist_c     = sr_q;
        load_c     = 1'b0;
        last_sym_c = 1'b0;

        // A new frame uses the freshly clamped select; otherwise the latched K.
        k_sel_c = (state_q == ST_IDLE) ? clamp_k(choose_constraint_length) : k_q;
        g0_c    = align_gen(gen_g0(k_sel_c));
        g1_c    = align_gen(gen_g1(k_sel_c));

        if (ov_q && out_ready) begin
            ov_d   = 1'b0;
            last_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_c) begin
                    load_c     = 1'b1;
                    shift_in_c = in_bit;
                    hist_c     = '0;
                    k_d        = k_sel_c;
                    fb_d       = FRAME_CNT_W'(1);
                    if (in_last) begin
                        state_d = ST_TAIL;
                        tail_d  = KW'(k_sel_c - 3'd1);
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (in_valid && in_ready_c) begin
                    load_c     = 1'b1;
                    shift_in_c = in_bit;
                    fb_d       = (&fb_q) ? fb_q : fb_q + FRAME_CNT_W'(1);
                    if (in_last) begin
                        state_d = ST_TAIL;
                        tail_d  = KW'(k_q - 3'd1);
                    end
                end
            end
            ST_TAIL: begin
                if (slot_free_c) begin
                    load_c = 1'b1;
                    tail_d = KW'(tail_q - 3'd1);
                    if (tail_q == 3'd1) begin
                        last_sym_c = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wnd_c = {shift_in_c, hist_c};

        if (load_c) begin
            ov_d   = 1'b1;
            enc_d  = {^(wnd_c & g0_c), ^(wnd_c & g1_c)};
            last_d = last_sym_c;
            // Clearing at frame end leaves no stale history below the K-1 window.
            sr_d   = last_sym_c ? '0 : wnd_c[MAX_K-1:1];
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            k_q     <= 3'd3;
            tail_q  <= '0;
            fb_q    <= '0;
            ov_q    <= 1'b0;
            enc_q   <= 2'b00;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            k_q     <= k_d;
            tail_q  <= tail_d;
            fb_q    <= fb_d;
            ov_q    <= ov_d;
            enc_q   <= enc_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready     = in_ready_c;
    assign encoded_bits = enc_q;
    assign out_valid    = ov_q;
    assign out_last     = last_q;
    assign busy         = busy_q;
    assign frame_bits   = fb_q;

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Self-checking bench for conv_encoder_sys: directed vector table, hand-written
// reset-abort sequence and randomized back-to-back frames against a
// window/generator reference model.
module tb_conv_encoder_sys;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  choose_constraint_length = 3'd3;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_bit = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  encoded_bits;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic [15:0] frame_bits;

    conv_encoder_sys #(.MAX_K(6), .FRAME_CNT_W(16)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .choose_constraint_length (choose_constraint_length),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .in_bit                   (in_bit),
        .in_last                  (in_last),
        .encoded_bits             (encoded_bits),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .out_last                 (out_last),
        .busy                     (busy),
        .frame_bits               (frame_bits)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int last_cnt = 0;
    int rdy_mode = 0;
    int unsigned rcnt = 0;

    logic [1:0] got_sym[$];
    logic       got_last[$];
    logic [1:0] exp_sym[$];
    logic       exp_last[$];

    typedef struct {
        logic [2:0]  ksel;
        int          n;
        logic [15:0] bits;   // bit i = i-th info bit
        int          nsym;
        logic [31:0] syms;   // symbol i at [2i+1:2i]
        int          mode;   // 0: ready high, 1: 1,0,0,1 pattern, 2: random
        bit          chg;    // change K select after first bit
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        rcnt++;
    end

    // Output monitor: collects symbols and checks stall stability.
    logic       stall_prev = 1'b0;
    logic [1:0] prev_enc = 2'b00;
    logic       prev_last = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_sym", 32'(encoded_bits), 32'(prev_enc));
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && !out_ready)
                check("in_ready_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                got_sym.push_back(encoded_bits);
                got_last.push_back(out_last);
                if (out_last) last_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            prev_enc   = encoded_bits;
            prev_last  = out_last;
        end
    end

    // Reference: each symbol is the generator-weighted parity of the last K bits.
    task automatic model_frame(input logic [2:0] ksel, input int n, input logic [15:0] bits);
        int k;
        int g0;
        int g1;
        k = (ksel < 3) ? 3 : ((ksel > 6) ? 6 : int'(ksel));
        case (k)
            3:       begin g0 = 'o7;  g1 = 'o5;  end
            4:       begin g0 = 'o15; g1 = 'o17; end
            5:       begin g0 = 'o23; g1 = 'o35; end
            default: begin g0 = 'o53; g1 = 'o75; end
        endcase
        for (int t = 0; t < n + k - 1; t++) begin
            logic p0;
            logic p1;
            p0 = 1'b0;
            p1 = 1'b0;
            for (int j = 0; j < k; j++) begin
                int  idx;
                logic u;
                idx = t - j;
                u = (idx >= 0 && idx < n) ? bits[idx] : 1'b0;
                p0 = p0 ^ (u & g0[k-1-j]);
                p1 = p1 ^ (u & g1[k-1-j]);
            end
            exp_sym.push_back({p0, p1});
            exp_last.push_back(t == n + k - 2);
        end
    endtask

    task automatic send_frame(input logic [2:0] ksel, input int n, input logic [15:0] bits, input bit chg);
        int guard;
        choose_constraint_length = ksel;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            in_last  = (i == n - 1);
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: in_ready 0 expected 1 for bit %0d", i);
            end
            @(posedge clk);
            #1;
            if (chg && i == 0)
                choose_constraint_length = ksel[2] ? 3'd3 : 3'd6;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic wait_lasts(input int target);
        int guard;
        guard = 0;
        while (last_cnt < target && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (last_cnt < target) begin
            total++;
            bad++;
            $display("FAIL last_timeout: got %0d out_last expected %0d", last_cnt, target);
        end
    endtask

    task automatic compare_q(input string name);
        int m;
        check($sformatf("%s_count", name), 32'(got_sym.size()), 32'(exp_sym.size()));
        m = (got_sym.size() < exp_sym.size()) ? got_sym.size() : exp_sym.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_sym%0d", name, i), 32'(got_sym[i]), 32'(exp_sym[i]));
            check($sformatf("%s_last%0d", name, i), 32'(got_last[i]), 32'(exp_last[i]));
        end
        got_sym.delete();
        got_last.delete();
        exp_sym.delete();
        exp_last.delete();
        last_cnt = 0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [31:0] s;
        s = v.syms;
        rdy_mode = v.mode;
        for (int i = 0; i < v.nsym; i++) begin
            exp_sym.push_back(s[2*i +: 2]);
            exp_last.push_back(i == v.nsym - 1);
        end
        send_frame(v.ksel, v.n, v.bits, v.chg);
        wait_lasts(1);
        @(negedge clk);
        check($sformatf("%s_frame_bits", name), 32'(frame_bits), 32'(v.n));
        check($sformatf("%s_busy", name), 32'(busy), 32'd0);
        compare_q(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{3'd3, 4, 16'b1101, 6, 32'b11_01_01_00_10_11, 0, 1'b0};
        vecs[1] = '{3'd3, 1, 16'b1,    3, 32'b11_10_11,          0, 1'b0};
        vecs[2] = '{3'd4, 1, 16'b1,    4, 32'b11_01_11_11,       0, 1'b0};
        vecs[3] = '{3'd5, 1, 16'b1,    5, 32'b11_10_01_01_11,    0, 1'b0};
        vecs[4] = '{3'd6, 1, 16'b1,    6, 32'b11_10_01_11_01_11, 0, 1'b0};
        vecs[5] = '{3'd7, 1, 16'b1,    6, 32'b11_10_01_11_01_11, 0, 1'b0};
        vecs[6] = '{3'd1, 1, 16'b1,    3, 32'b11_10_11,          0, 1'b0};
        vecs[7] = '{3'd3, 4, 16'b1101, 6, 32'b11_01_01_00_10_11, 1, 1'b0};
        vecs[8] = '{3'd3, 4, 16'b1101, 6, 32'b11_01_01_00_10_11, 2, 1'b1};
        vecs[9] = '{3'd0, 4, 16'b1101, 6, 32'b11_01_01_00_10_11, 0, 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_encoded", 32'(encoded_bits), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_bits", 32'(frame_bits), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort a K=5 frame in its tail with an asynchronous reset.
        rdy_mode = 0;
        send_frame(3'd5, 3, 16'b011, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_frame_bits", 32'(frame_bits), 32'd0);
        check("abort_no_last_seen", 32'(last_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got_sym.delete();
        got_last.delete();
        last_cnt = 0;
        @(posedge clk);
        #1;
        run_vec(vecs[1], "post_abort");

        // Randomized back-to-back frame pairs against the reference model.
        for (int it = 0; it < 25; it++) begin
            logic [2:0]  ka;
            logic [2:0]  kb;
            int          na;
            int          nb;
            logic [15:0] ba;
            logic [15:0] bb;
            bit          ca;
            ka = 3'($urandom_range(0, 7));
            kb = 3'($urandom_range(0, 7));
            na = $urandom_range(1, 12);
            nb = $urandom_range(1, 12);
            ba = 16'($urandom);
            bb = 16'($urandom);
            ca = 1'($urandom_range(0, 1));
            rdy_mode = (it % 3 == 0) ? 0 : 2;
            model_frame(ka, na, ba);
            model_frame(kb, nb, bb);
            send_frame(ka, na, ba, ca);
            send_frame(kb, nb, bb, 1'b0);
            wait_lasts(2);
            @(negedge clk);
            check($sformatf("rnd%0d_frame_bits", it), 32'(frame_bits), 32'(nb));
            check($sformatf("rnd%0d_busy", it), 32'(busy), 32'd0);
            compare_q($sformatf("rnd%0d", it));
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
